// File: rtl/c7seg_scan.sv
// Four-digit multiplexed 7-segment scan controller with dead-time guard and
// double-buffered display value. Define C7SEG_LZB_EN for leading-zero blanking.
module c7seg_scan #(
    parameter int unsigned DIV   = 5000,
    parameter int unsigned GUARD = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in_data,
    input  logic        in_load,
    input  logic        in_en,
    output logic [3:0]  o_digit,
    output logic [3:0]  o_an,
    output logic        o_busy,
    output logic        o_frame
);

    typedef enum logic {PH_GUARD, PH_ON} phase_t;

    localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
    localparam logic [15:0] CNT_GUARD = 16'(GUARD);

    logic [15:0] cnt, cnt_nx;
    logic [1:0]  idx, idx_nx;
    logic [15:0] disp, disp_nx;
    logic [15:0] pend, pend_nx;
    logic        busy, busy_nx;
    logic        wrap, frame_nx;
    phase_t      phase_nx;
    logic [3:0]  blank;
    logic [3:0]  an_nx;

    always_comb begin
        wrap     = (cnt == CNT_LAST);
        cnt_nx   = wrap ? '0 : cnt + 16'd1;
        idx_nx   = wrap ? idx + 2'd1 : idx;
        frame_nx = wrap && (idx == 2'd3);
        phase_nx = (cnt_nx >= CNT_GUARD) ? PH_ON : PH_GUARD;
        // Old pend moves to disp before a coincident load overwrites it.
        disp_nx  = (frame_nx && busy) ? pend : disp;
        pend_nx  = in_load ? in_data : pend;
        busy_nx  = in_load ? 1'b1 : (frame_nx ? 1'b0 : busy);
    end

`ifdef C7SEG_LZB_EN
    always_comb begin
        blank    = '0;
        blank[3] = (disp_nx[15:12] == 4'h0);
        blank[2] = (disp_nx[15:8]  == 8'h00);
        blank[1] = (disp_nx[15:4]  == 12'h000);
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    always_comb begin
        an_nx = '1;
        if (phase_nx == PH_ON && in_en && !blank[idx_nx])
            an_nx[idx_nx] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            idx     <= '0;
            disp    <= '0;
            pend    <= '0;
            busy    <= 1'b0;
            o_digit <= '0;
            o_an    <= '1;
            o_frame <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            disp    <= disp_nx;
            pend    <= pend_nx;
            busy    <= busy_nx;
            o_digit <= disp_nx[{idx_nx, 2'b00} +: 4];
            o_an    <= an_nx;
            o_frame <= frame_nx;
        end
    end

    assign o_busy = busy;

endmodule

// File: tb/tb_c7seg_scan.sv
// Self-checking bench for c7seg_scan: small-parameter instance plus a
// default-parameter instance, compared against a time-based reference model.
module tb_c7seg_scan;

    localparam int DIV    = 8;
    localparam int GUARD  = 2;
    localparam int DDIV   = 5000;
    localparam int DGUARD = 16;
`ifdef C7SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_load;
    logic        in_en;
    logic [3:0]  o_digit, o_an;
    logic        o_busy, o_frame;

    logic [15:0] in_data_d;
    logic        in_load_d, in_en_d;
    logic [3:0]  o_digit_d, o_an_d;
    logic        o_busy_d, o_frame_d;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release and the buffered values.
    int          e;
    logic [15:0] m_disp, m_pend;
    logic        m_busy;
    logic [3:0]  x_an, x_digit, x_an_d;
    logic        x_busy, x_frame, x_frame_d;

    always #5 clk = ~clk;

    c7seg_scan #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_load(in_load),
        .in_en(in_en), .o_digit(o_digit), .o_an(o_an), .o_busy(o_busy),
        .o_frame(o_frame)
    );

    c7seg_scan #(.DIV(DDIV), .GUARD(DGUARD)) dut_d (
        .clk(clk), .reset_n(reset_n), .in_data(in_data_d), .in_load(in_load_d),
        .in_en(in_en_d), .o_digit(o_digit_d), .o_an(o_an_d), .o_busy(o_busy_d),
        .o_frame(o_frame_d)
    );

    function automatic logic [3:0] nib(input logic [15:0] d, input int i);
        return 4'((d >> (4 * i)) & 16'h000F);
    endfunction

    function automatic logic [3:0] an_model(input int div, input int guard, input int ev,
                                            input logic en, input logic [15:0] d);
        int       c;
        int       i;
        bit       blanked;
        logic [3:0] r;
        c = ev % div;
        i = (ev / div) % 4;
        r = 4'b1111;
        blanked = LZB && (i > 0) && ((d >> (4 * i)) == 16'h0);
        if (c >= guard && en && !blanked) r[i] = 1'b0;
        return r;
    endfunction

    task automatic step();
        bit bnd;
        @(posedge clk);
        e++;
        bnd = (e % (4 * DIV)) == 0;
        if (bnd && m_busy) m_disp = m_pend;
        if (in_load) begin
            m_pend = in_data;
            m_busy = 1'b1;
        end else if (bnd) begin
            m_busy = 1'b0;
        end
        x_frame   = bnd;
        x_busy    = m_busy;
        x_digit   = nib(m_disp, (e / DIV) % 4);
        x_an      = an_model(DIV, GUARD, e, in_en, m_disp);
        x_an_d    = an_model(DDIV, DGUARD, e, in_en_d, 16'h0000);
        x_frame_d = (e % (4 * DDIV)) == 0;
        #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        in_load = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        e = 0; m_disp = '0; m_pend = '0; m_busy = 1'b0;
    endtask

    task automatic test_reset();
        in_en = 1'b1;
        while (e < 2 * DIV + 5) step();
        if (o_an !== x_an) begin errors++; $display("FAIL pre_reset_an got %b exp %b", o_an, x_an); end
        checks++;
        #2 reset_n = 1'b0;
        #1;
        if (o_an !== 4'b1111 || o_digit !== 4'h0 || o_busy !== 1'b0 || o_frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_async an=%b digit=%h busy=%b frame=%b exp 1111/0/0/0", o_an, o_digit, o_busy, o_frame);
        end
        checks++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        e = 0; m_disp = '0; m_pend = '0; m_busy = 1'b0;
        repeat (12) begin
            step();
            if (o_an !== x_an) begin errors++; $display("FAIL reset_an e=%0d got %b exp %b", e, o_an, x_an); end
            checks++;
            if (o_digit !== 4'h0 || o_busy !== 1'b0) begin
                errors++; $display("FAIL reset_state e=%0d digit=%h busy=%b exp 0/0", e, o_digit, o_busy);
            end
            checks++;
            if (e == 1 && o_an !== 4'b1111) begin errors++; $display("FAIL reset_e1 got %b exp 1111", o_an); end
            if (e == 2 && o_an !== 4'b1110) begin errors++; $display("FAIL reset_e2 got %b exp 1110", o_an); end
            if (e == 8 && o_an !== 4'b1111) begin errors++; $display("FAIL reset_e8 got %b exp 1111", o_an); end
            if (e == 10 && o_an !== (LZB ? 4'b1111 : 4'b1101)) begin
                errors++; $display("FAIL reset_e10 got %b exp %b", o_an, LZB ? 4'b1111 : 4'b1101);
            end
            if (e == 1 || e == 2 || e == 8 || e == 10) checks++;
        end
    endtask

    task automatic test_load();
        logic [3:0] dg [4];
        logic [3:0] an [4];
        dg = '{4'hF, 4'h2, 4'hA, 4'h1};
        an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        do_reset();
        in_en = 1'b1;
        while (e < 4) step();
        in_data = 16'h1A2F; in_load = 1'b1;
        step();
        in_load = 1'b0;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", o_busy); end
        checks++;
        while (e < 4 * DIV) begin
            step();
            if (o_busy !== x_busy || o_frame !== x_frame) begin
                errors++; $display("FAIL load_wait e=%0d busy=%b frame=%b exp %b/%b", e, o_busy, o_frame, x_busy, x_frame);
            end
            checks++;
        end
        if (o_frame !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL load_wrap frame=%b busy=%b exp 1/0", o_frame, o_busy);
        end
        checks++;
        for (int k = 0; k < 4 * DIV; k++) begin
            if ((e % DIV) >= GUARD) begin
                if (o_digit !== dg[(e / DIV) % 4] || o_an !== an[(e / DIV) % 4]) begin
                    errors++;
                    $display("FAIL load_scan e=%0d digit=%h an=%b exp %h/%b", e, o_digit, o_an,
                             dg[(e / DIV) % 4], an[(e / DIV) % 4]);
                end
                checks++;
            end
            step();
        end
    endtask

    task automatic test_overwrite();
        do_reset();
        in_en = 1'b1;
        while (e < 3) step();
        in_data = 16'h1111; in_load = 1'b1; step(); in_load = 1'b0;
        while (e < 10) step();
        in_data = 16'h2222; in_load = 1'b1; step(); in_load = 1'b0;
        while (e < 12 * DIV) begin
            step();
            if (o_digit === 4'h1 || o_digit !== x_digit) begin
                errors++; $display("FAIL overwrite_digit e=%0d got %h exp %h", e, o_digit, x_digit);
            end
            checks++;
            if (e >= 4 * DIV && o_digit !== 4'h2) begin
                errors++; $display("FAIL overwrite_last e=%0d got %h exp 2", e, o_digit);
            end
            if (e >= 4 * DIV) checks++;
        end
    endtask

    task automatic test_wrap_load();
        logic [15:0] r;
        r = 16'h8000 | 16'($urandom);
        do_reset();
        in_en = 1'b1;
        while (e < 5) step();
        in_data = 16'h3333; in_load = 1'b1; step(); in_load = 1'b0;
        while (e < 4 * DIV - 1) step();
        in_data = r; in_load = 1'b1; step(); in_load = 1'b0;
        if (o_frame !== 1'b1 || o_busy !== 1'b1 || o_digit !== 4'h3) begin
            errors++; $display("FAIL wrapload_edge frame=%b busy=%b digit=%h exp 1/1/3", o_frame, o_busy, o_digit);
        end
        checks++;
        while (e < 8 * DIV) begin
            step();
            if (e < 8 * DIV && (o_busy !== 1'b1 || o_digit !== 4'h3)) begin
                errors++; $display("FAIL wrapload_hold e=%0d busy=%b digit=%h exp 1/3", e, o_busy, o_digit);
            end
            if (e < 8 * DIV) checks++;
        end
        if (o_busy !== 1'b0 || o_frame !== 1'b1 || o_digit !== r[3:0]) begin
            errors++; $display("FAIL wrapload_next busy=%b frame=%b digit=%h exp 0/1/%h", o_busy, o_frame, o_digit, r[3:0]);
        end
        checks++;
    endtask

    task automatic test_default_disabled();
        do_reset();
        in_en_d = 1'b0;
        for (int k = 0; k < 8 * DDIV + 2; k++) begin
            step();
            if (o_an_d !== 4'b1111 || o_an_d !== x_an_d) begin
                errors++; $display("FAIL dflt_an e=%0d got %b exp 1111", e, o_an_d);
            end
            checks++;
            if (o_frame_d !== x_frame_d) begin
                errors++; $display("FAIL dflt_frame e=%0d got %b exp %b", e, o_frame_d, x_frame_d);
            end
            checks++;
        end
        in_en_d = 1'b1;
        while ((e % DDIV) != DGUARD + 3) step();
        if (o_an_d !== x_an_d || o_digit_d !== 4'h0) begin
            errors++; $display("FAIL dflt_enable an=%b digit=%h exp %b/0", o_an_d, o_digit_d, x_an_d);
        end
        checks++;
        in_en_d = 1'b0;
    endtask

    task automatic test_lzb();
        logic [3:0] ex;
        do_reset();
        in_en = 1'b1;
        step();
        in_data = 16'h0005; in_load = 1'b1; step(); in_load = 1'b0;
        while (e < 16 * DIV) begin
            step();
            if (e == 8 * DIV) begin
                in_data = 16'h0000; in_load = 1'b1; step(); in_load = 1'b0;
            end
            ex = 4'b1111;
            if ((e % DIV) >= GUARD && (!LZB || ((e / DIV) % 4) == 0)) ex[(e / DIV) % 4] = 1'b0;
            if (e >= 4 * DIV) begin
                if (o_an !== ex || o_an !== x_an) begin
                    errors++; $display("FAIL lzb_an e=%0d got %b exp %b", e, o_an, ex);
                end
                checks++;
                if (o_digit !== x_digit) begin
                    errors++; $display("FAIL lzb_digit e=%0d got %h exp %h", e, o_digit, x_digit);
                end
                checks++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            in_en   = ($urandom_range(0, 7) != 0);
            in_load = ($urandom_range(0, 15) == 0);
            in_data = 16'($urandom);
            step();
            if (o_an !== x_an || o_digit !== x_digit) begin
                errors++; $display("FAIL rand_scan e=%0d an=%b digit=%h exp %b/%h", e, o_an, o_digit, x_an, x_digit);
            end
            checks++;
            if (o_busy !== x_busy || o_frame !== x_frame) begin
                errors++; $display("FAIL rand_ctl e=%0d busy=%b frame=%b exp %b/%b", e, o_busy, o_frame, x_busy, x_frame);
            end
            checks++;
        end
        in_load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        in_data = '0; in_load = 1'b0; in_en = 1'b0;
        in_data_d = '0; in_load_d = 1'b0; in_en_d = 1'b0;
        e = 0; m_disp = '0; m_pend = '0; m_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_load();
        test_overwrite();
        test_wrap_load();
        test_lzb();
        test_random();
        test_default_disabled();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
